// File: rtl/line_mem_responder_pkg.sv
// Shared line-memory types: line geometry and responder FSM states.
// Imported by line_mem_array and line_mem_responder.
package rv32i_types;

  localparam int LINE_BITS = 256;
  localparam int OFF_BITS  = 5;
  localparam int CNT_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    RECOVER
  } mem_state_e;

  function automatic logic [CNT_BITS-1:0] cnt_load(input int lat);
    return CNT_BITS'(lat - 1);
  endfunction

endpackage

// File: rtl/line_mem_responder_array.sv
// Line storage: one write port, one registered read port.
// Contents are not reset; only the read register clears.
module line_mem_array
  import rv32i_types::*;
#(
  parameter int IDX_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [IDX_BITS-1:0]  waddr,
  input  logic [LINE_BITS-1:0] wline,
  input  logic                 re,
  input  logic [IDX_BITS-1:0]  raddr,
  output logic [LINE_BITS-1:0] rline
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [LINE_BITS-1:0] mem [DEPTH];

  // Write port: storage survives reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wline;
    end
  end

  // Registered read port, held between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rline <= '0;
    end else if (re) begin
      rline <= mem[raddr];
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency line memory responder (IDLE/BUSY/RESP/RECOVER).
// MEM_PROTOCOL_CHECK_EN adds the sticky protocol_err checker port.
module line_mem_responder
  import rv32i_types::*;
#(
  parameter int IDX_BITS = 8,
  parameter int LATENCY  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          address,
  input  logic [LINE_BITS-1:0] wdata,
  output logic                 resp,
  output logic [LINE_BITS-1:0] rdata
`ifdef MEM_PROTOCOL_CHECK_EN
  ,
  output logic                 protocol_err
`endif
);

  mem_state_e           state;
  logic [CNT_BITS-1:0]  cnt;
  logic                 op_wr;
  logic [IDX_BITS-1:0]  idx;
  logic [LINE_BITS-1:0] wdata_q;
  logic [IDX_BITS-1:0]  req_idx;
  logic                 req;
  logic                 last;
  logic                 rd_en;
  logic                 wr_en;
  logic                 unused_addr;

  assign req     = read | write;
  assign req_idx = address[IDX_BITS+OFF_BITS-1:OFF_BITS];
  assign last    = (state == BUSY) && req && (cnt == 1);
  assign rd_en   = last && !op_wr;
  assign wr_en   = (state == RESP) && op_wr;

  assign unused_addr = ^address;

  // Sequencer: latch request, count down, pulse resp, recover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      resp    <= 1'b0;
      op_wr   <= 1'b0;
      idx     <= '0;
      wdata_q <= '0;
    end else begin
      resp <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            op_wr   <= write;
            idx     <= req_idx;
            wdata_q <= wdata;
            cnt     <= cnt_load(LATENCY);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!req) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == 1) begin
            cnt   <= '0;
            resp  <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= RECOVER;
        end
        RECOVER: begin
          state <= IDLE;
        end
      endcase
    end
  end

  line_mem_array #(
    .IDX_BITS (IDX_BITS)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (idx),
    .wline (wdata_q),
    .re    (rd_en),
    .raddr (idx),
    .rline (rdata)
  );

`ifdef MEM_PROTOCOL_CHECK_EN
  logic [31-OFF_BITS:0] addr_q;

  // Remember the full line address seen at request time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (state == IDLE && req) begin
      addr_q <= address[31:OFF_BITS];
    end
  end

  // Sticky flag: dual request, abort, or unstable inputs while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      protocol_err <= 1'b0;
    end else if (state == IDLE) begin
      if (read && write) begin
        protocol_err <= 1'b1;
      end
    end else if (state == BUSY) begin
      if (!req) begin
        protocol_err <= 1'b1;
      end else if (address[31:OFF_BITS] != addr_q) begin
        protocol_err <= 1'b1;
      end else if (write && wdata != wdata_q) begin
        protocol_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Randomized bench for line_mem_responder against a queue-based model.
// Build with MEM_PROTOCOL_CHECK_EN to also check protocol_err.
module tb_line_mem_responder;
  import rv32i_types::*;

  localparam int IDX_BITS = 8;
  localparam int L        = 10;
  localparam int DEPTH    = 1 << IDX_BITS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  address = '0;
  logic [255:0] wdata = '0;
  logic         resp;
  logic [255:0] rdata;
`ifdef MEM_PROTOCOL_CHECK_EN
  logic         protocol_err;
`endif

  line_mem_responder #(
    .IDX_BITS (IDX_BITS),
    .LATENCY  (L)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .read         (read),
    .write        (write),
    .address      (address),
    .wdata        (wdata),
    .resp         (resp),
    .rdata        (rdata)
`ifdef MEM_PROTOCOL_CHECK_EN
    ,
    .protocol_err (protocol_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           at;
    bit           rd;
    logic [255:0] data;
  } exp_t;

  exp_t         expq[$];
  int           resp_log[$];
  logic [255:0] ref_mem [DEPTH];
  logic [255:0] exp_rdata = '0;
  int           perr_cyc = -1;
  bit           chk_en = 1'b0;
  int           n_vec = 0;
  int           n_bad = 0;

  function automatic void chk(string nm, logic [255:0] act,
                              logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Per-cycle compare of resp/rdata (and protocol_err) with the model.
  bit want;
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      want = 1'b0;
      if (expq.size() > 0 && expq[0].at == cyc) begin
        want = 1'b1;
        if (expq[0].rd) exp_rdata = expq[0].data;
        void'(expq.pop_front());
      end
      if (resp === 1'b1) resp_log.push_back(cyc);
      chk("resp", 256'(resp), 256'(want));
      chk("rdata", rdata, exp_rdata);
`ifdef MEM_PROTOCOL_CHECK_EN
      chk("protocol_err", 256'(protocol_err),
          256'(perr_cyc >= 0 && cyc >= perr_cyc));
`endif
    end
  end

  // One transaction from an idle DUT; abort_k >= 0 drops the
  // request at the negedge of cyc == s+abort_k (before resp).
  task automatic op(input bit rd, input bit wr, input logic [31:0] a,
                    input logic [255:0] d, input int abort_k,
                    output int s);
    logic [IDX_BITS-1:0] ix;
    ix = a[IDX_BITS+4:5];
    read = rd;
    write = wr;
    address = a;
    wdata = d;
    s = cyc + 1;
    if (rd && wr && perr_cyc < 0) perr_cyc = s;
    if (abort_k >= 0) begin
      while (cyc < s + abort_k) @(negedge clk);
      read = 1'b0;
      write = 1'b0;
      if (perr_cyc < 0) perr_cyc = s + abort_k + 1;
      @(negedge clk);
    end else begin
      expq.push_back('{s + L - 1, !wr, wr ? '0 : ref_mem[ix]});
      while (cyc < s + L - 1) @(negedge clk);
      read = 1'b0;
      write = 1'b0;
      if (wr) ref_mem[ix] = d;
      repeat (2) @(negedge clk);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  logic [255:0] a5;
  logic [255:0] one;
  logic [255:0] dd;
  logic [31:0]  ra;
  int           s;
  int           s2;
  int           r;

  initial begin
    a5  = {32{8'hA5}};
    one = 256'h1;

    #1;
    chk("reset_resp", 256'(resp), 256'(0));
    chk("reset_rdata", rdata, '0);
    repeat (3) @(negedge clk);

    // Release reset and request on the very next edge.
    rst_n = 1'b1;
    chk_en = 1'b1;
    op(1'b0, 1'b1, 32'h0000_1000, a5, -1, s);

    resp_log.delete();
    op(1'b1, 1'b0, 32'h0000_1000, '0, -1, s);
    chk("read_a5", rdata, a5);
    if (resp_log.size() == 1)
      chk("latency", 256'(resp_log[0] + 1 - s), 256'(10));
    else
      chk("latency_count", 256'(resp_log.size()), 256'(1));

    // Aliasing: 0x2020 maps onto line 1 like 0x0020.
    op(1'b0, 1'b1, 32'h0000_0020, one, -1, s);
    op(1'b1, 1'b0, 32'h0000_2020, '0, -1, s);
    chk("alias", rdata, one);

    // Abort: write dropped in BUSY cycle 4 leaves the line alone.
    op(1'b0, 1'b1, 32'h0000_1000, ~a5, 3, s);
    op(1'b1, 1'b0, 32'h0000_1000, '0, -1, s);
    chk("abort_keeps", rdata, a5);

    // Held read: two services spaced exactly L+2 apart.
    resp_log.delete();
    read = 1'b1;
    address = 32'h0000_0020;
    s = cyc + 1;
    expq.push_back('{s + L - 1, 1'b1, one});
    expq.push_back('{s + 2*L + 1, 1'b1, one});
    while (cyc < s + 2*L + 1) @(negedge clk);
    read = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_count", 256'(resp_log.size()), 256'(2));
    if (resp_log.size() == 2)
      chk("held_gap", 256'(resp_log[1] - resp_log[0]), 256'(12));

    // Reset during BUSY cycle 5 of a write.
    read = 1'b0;
    write = 1'b1;
    address = 32'h0000_1000;
    wdata = ~a5;
    s = cyc + 1;
    while (cyc < s + 4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_resp", 256'(resp), 256'(0));
    chk("rst_rdata", rdata, '0);
    expq.delete();
    exp_rdata = '0;
    perr_cyc = -1;
    write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    op(1'b1, 1'b0, 32'h0000_1000, '0, -1, s);
    chk("rst_keeps", rdata, a5);

    // Read and write together resolve to a write.
    dd = 256'hDEAD_BEEF;
    op(1'b1, 1'b1, 32'h0000_0040, dd, -1, s);
    op(1'b1, 1'b0, 32'h0000_0040, '0, -1, s);
    chk("both_is_write", rdata, dd);
`ifdef MEM_PROTOCOL_CHECK_EN
    chk("perr_set", 256'(protocol_err), 256'(1));
`endif

    // Prefill lines 0..15, then random traffic over them.
    for (int i = 0; i < 16; i++) begin
      op(1'b0, 1'b1, 32'(i) << 5, rnd_line(), -1, s);
    end
    for (int n = 0; n < 60; n++) begin
      ra = $urandom;
      ra[IDX_BITS+4:5] = 8'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      s2 = ($urandom_range(0, 5) == 0) ? $urandom_range(0, L - 2) : -1;
      op(r < 5 || r == 9, r >= 5, ra, rnd_line(), s2, s);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    if (expq.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL pending_resp: got %0d left expected 0", expq.size());
    end
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/line_mem_responder.md
LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 SHALL have parameter IDX_BITS, default 8, meaning log2 of the number of 256-bit lines stored.
REQ-002 SHALL have parameter LATENCY, default 10, meaning cycles from request sample to resp; legal range 2..255.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port read, input, 1, initiator line-read request, level, held until resp.
REQ-006 SHALL have port write, input, 1, initiator line-write request, level, held until resp.
REQ-007 SHALL have port address, input, 32, byte address; bits [4:0] ignored; line index = address[IDX_BITS+4:5].
REQ-008 SHALL have port wdata, input, 256, write line data, stable while write is high.
REQ-009 SHALL have port resp, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port rdata, output, 256, read line data, valid in the resp cycle.
REQ-011 SHALL have port protocol_err, output, 1, sticky protocol-violation flag, present only under MEM_PROTOCOL_CHECK_EN.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, RESP, RECOVER.
REQ-013 IDLE: on an edge with read or write high, SHALL latch the operation, index and wdata, load the counter with LATENCY-1, and go to BUSY.
REQ-014 BUSY: SHALL decrement the counter each edge; at counter 1, SHALL go to RESP, so resp is high exactly LATENCY cycles after the sampling edge.
REQ-015 BUSY: if both read and write are low on an edge, SHALL abort to IDLE, with no memory update and no resp.
REQ-016 RESP: SHALL drive resp=1 for exactly one cycle; for reads, rdata SHALL be the registered line at the latched index.
REQ-017 RESP: for writes, the line SHALL be updated on the edge ending the resp cycle, and rdata SHALL be unchanged.
REQ-018 RECOVER: SHALL last one cycle and ignore all requests (prevents double service while the initiator drops its request), then go to IDLE.
REQ-019 Back-to-back: minimum request-to-request spacing SHALL be LATENCY+2 cycles.
REQ-020 If read and write are both high when sampled, the operation SHALL be a write.
REQ-021 Address changes during BUSY SHALL be ignored; the latched index governs.
REQ-022 Address bits above IDX_BITS+4 SHALL be ignored, so addresses alias (wrap) modulo the array size.
REQ-023 Memory contents SHALL be uninitialised; a read of a never-written line returns X in simulation.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, resp 0, rdata 0, counter 0, and protocol_err 0.
REQ-025 Reset mid-operation SHALL abandon the transaction; no write commits, and the storage array is not cleared.
REQ-026 The first request SHALL be sampled on the first rising edge after rst_n rises.

Configuration
REQ-027 Macro MEM_PROTOCOL_CHECK_EN defined: protocol_err SHALL set and hold on any of these: read and write both high, abort in BUSY, address or wdata change in BUSY.
REQ-028 Macro MEM_PROTOCOL_CHECK_EN undefined: the protocol_err port and its logic SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-029 Package rv32i_types SHALL hold the line-width constant (256), the offset-bits constant (5), and the FSM state enum typedef.
REQ-030 Storage SHALL be a sub-module line_mem_array: one write port, one registered read port, depth 2**IDX_BITS.
REQ-031 The FSM, counter and checker SHALL reside in line_mem_responder.

Verification
REQ-032 Read test: write line 0x1000 with 256'hA5..A5, then read 0x1000 -> resp at cycle LATENCY (10) of each request; rdata = A5..A5.
REQ-033 Aliasing test: IDX_BITS=8; write 0x0000_0020 = 256'h1, then read 0x0000_2020 -> rdata = 256'h1.
REQ-034 Abort test: write request dropped at cycle 4 of BUSY -> no resp; a subsequent read returns the old line value.
REQ-035 Held-request test: request held high through resp -> exactly one resp; next resp no earlier than LATENCY+2 cycles after the first.
REQ-036 Reset test: rst_n pulsed low at BUSY cycle 5 of a write -> resp 0 immediately; the line is unchanged after reset.
REQ-037 Checker test, with MEM_PROTOCOL_CHECK_EN: read=write=1 -> write performed, protocol_err=1 and held until rst_n.
